// File: rtl/lpc_pkg.sv
// Shared LPC definitions: slave state encoding and the protocol nibble codes.
package lpc_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CYCTYP,
        ADDR,
        WDATA,
        TAR0,
        TAR1,
        SWAIT,
        SYNC,
        RDATA0,
        RDATA1,
        TAR2A,
        TAR2B,
        WAIT_END
    } lpcState_e;

    // START nibble that opens a target cycle
    localparam logic [3:0] START_CODE      = 4'h0;

    // CYCTYP/DIR field (LAD[3:1]) for the cycles we service
    localparam logic [2:0] CYC_IO_RD       = 3'b000;
    localparam logic [2:0] CYC_IO_WR       = 3'b001;

    // SYNC nibbles
    localparam logic [3:0] SYNC_READY      = 4'h0;
    localparam logic [3:0] SYNC_SHORT_WAIT = 4'h5;

    // Value driven while handing the bus back to the host
    localparam logic [3:0] TAR_VALUE       = 4'hF;

endpackage

// File: rtl/lpc_addr_decode.sv
// Combinational I/O window match; also used by the POST-code snooper.
module lpc_addr_decode
    import lpc_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0800,
    parameter logic [15:0] ADDR_MASK = 16'hFFE0
) (
    input  logic [15:0] Addr,
    output logic        Hit
);

    logic [15:0] bitOk;

    // A bit matches when it is masked out or equals the base address bit
    for (genvar gi = 0; gi < 16; gi++) begin : g_bit
        assign bitOk[gi] = ~ADDR_MASK[gi] | (Addr[gi] == BASE_ADDR[gi]);
    end

    assign Hit = &bitOk;

endmodule

// File: rtl/lpc_io_slave.sv
// LPC I/O read/write target feeding the CPLD register read-mux and write block.
module lpc_io_slave
    import lpc_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'h0800,
    parameter logic [15:0] ADDR_MASK  = 16'hFFE0,
    parameter int          SYNC_WAITS = 0
) (
    input  logic        Mclk,
    input  logic        Reset,
    input  logic        LFrameN,
    input  logic [3:0]  LadIn,
    output logic [3:0]  LadOut,
    output logic        LadOe,
    output logic [15:0] DevAddr,
    output logic        RdDev_En,
    input  logic [7:0]  RdDev_Data,
    output logic        WrDev_En,
    output logic [7:0]  WrDev_Data
);

    // Last value of the wait counter before moving on to the ready SYNC
    localparam logic [2:0] LastWait = 3'((SYNC_WAITS > 0) ? SYNC_WAITS - 1 : 0);

    lpcState_e   stateReg, stateNext;
    logic [2:0]  cntReg, cntNext;
    logic        isWriteReg, isWriteNext;
    logic [7:0]  holdReg, holdNext;

    logic [15:0] devAddrNext;
    logic [7:0]  wrDataNext;
    logic [3:0]  ladOutNext;
    logic        ladOeNext;
    logic        rdEnNext;
    logic        wrEnNext;

    // Address as it will look after the current nibble is shifted in
    logic [15:0] addrShift;
    logic        addrHit;

    assign addrShift = {DevAddr[11:0], LadIn};

    lpc_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .ADDR_MASK (ADDR_MASK)
    ) u_addr_decode (
        .Addr (addrShift),
        .Hit  (addrHit)
    );

    // Next-state, datapath and next-output logic; outputs follow the next state
    always_comb begin
        stateNext   = stateReg;
        cntNext     = 3'd0;
        isWriteNext = isWriteReg;
        holdNext    = holdReg;
        devAddrNext = DevAddr;
        wrDataNext  = WrDev_Data;

        if (!LFrameN) begin
            // START (or an abort that restarts) overrides whatever was in flight
            stateNext = (LadIn == START_CODE) ? CYCTYP : IDLE;
        end else begin
            case (stateReg)
                IDLE: stateNext = IDLE;
                CYCTYP: begin
                    if (LadIn[3:1] == CYC_IO_RD) begin
                        isWriteNext = 1'b0;
                        stateNext   = ADDR;
                    end else if (LadIn[3:1] == CYC_IO_WR) begin
                        isWriteNext = 1'b1;
                        stateNext   = ADDR;
                    end else begin
                        stateNext   = WAIT_END;
                    end
                end
                ADDR: begin
                    devAddrNext = addrShift;
                    if (cntReg == 3'd3) begin
                        if (!addrHit)
                            stateNext = WAIT_END;
                        else
                            stateNext = isWriteReg ? WDATA : TAR0;
                    end else begin
                        cntNext = cntReg + 3'd1;
                    end
                end
                WDATA: begin
                    if (cntReg == 3'd0) begin
                        wrDataNext[3:0] = LadIn;
                        cntNext         = 3'd1;
                    end else begin
                        wrDataNext[7:4] = LadIn;
                        stateNext       = TAR0;
                    end
                end
                TAR0: stateNext = TAR1;
                TAR1: stateNext = (SYNC_WAITS > 0) ? SWAIT : SYNC;
                SWAIT: begin
                    if (cntReg == LastWait)
                        stateNext = SYNC;
                    else
                        cntNext = cntReg + 3'd1;
                end
                SYNC: begin
                    if (!isWriteReg)
                        holdNext = RdDev_Data;
                    stateNext = isWriteReg ? TAR2A : RDATA0;
                end
                RDATA0:   stateNext = RDATA1;
                RDATA1:   stateNext = TAR2A;
                TAR2A:    stateNext = TAR2B;
                TAR2B:    stateNext = IDLE;
                WAIT_END: stateNext = WAIT_END;
                default:  stateNext = IDLE;
            endcase
        end

        ladOeNext  = 1'b0;
        ladOutNext = TAR_VALUE;
        rdEnNext   = 1'b0;
        wrEnNext   = 1'b0;
        case (stateNext)
            TAR1: rdEnNext = ~isWriteNext;
            SWAIT: begin
                ladOeNext  = 1'b1;
                ladOutNext = SYNC_SHORT_WAIT;
            end
            SYNC: begin
                ladOeNext  = 1'b1;
                ladOutNext = SYNC_READY;
                wrEnNext   = isWriteNext;
            end
            RDATA0: begin
                // Hold register is loaded on this same edge, so use its next value
                ladOeNext  = 1'b1;
                ladOutNext = holdNext[3:0];
            end
            RDATA1: begin
                ladOeNext  = 1'b1;
                ladOutNext = holdReg[7:4];
            end
            TAR2A: ladOeNext = 1'b1;
            default: ladOeNext = 1'b0;
        endcase
    end

    // State and registered outputs; reset releases LAD immediately
    always_ff @(posedge Mclk or posedge Reset) begin
        if (Reset) begin
            stateReg   <= IDLE;
            cntReg     <= 3'd0;
            isWriteReg <= 1'b0;
            holdReg    <= 8'h00;
            DevAddr    <= 16'h0000;
            WrDev_Data <= 8'h00;
            LadOut     <= TAR_VALUE;
            LadOe      <= 1'b0;
            RdDev_En   <= 1'b0;
            WrDev_En   <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            cntReg     <= cntNext;
            isWriteReg <= isWriteNext;
            holdReg    <= holdNext;
            DevAddr    <= devAddrNext;
            WrDev_Data <= wrDataNext;
            LadOut     <= ladOutNext;
            LadOe      <= ladOeNext;
            RdDev_En   <= rdEnNext;
            WrDev_En   <= wrEnNext;
        end
    end

endmodule

// File: tb/tb_lpc_io_slave.sv
// Scoreboard bench: two slaves (0 and 3 wait states) share one host stimulus.
module tb_lpc_io_slave;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    logic        Mclk     = 1'b0;
    logic        Reset    = 1'b1;
    logic        LFrameN  = 1'b1;
    logic [3:0]  LadIn    = 4'hF;
    logic [7:0]  muxValue = 8'h00;

    logic [3:0]  ladOut [2];
    logic        ladOe  [2];
    logic [15:0] devAddr[2];
    logic        rdEn   [2];
    logic        wrEn   [2];
    logic [7:0]  wrData [2];

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expQ0[$];
    exp_t expQ1[$];

    always #5 Mclk = ~Mclk;

    always @(posedge Mclk) cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] ladEv(input logic [3:0] n);
        return {4'h1, 24'h0, n};
    endfunction

    task automatic pushExp(input int k, input int c, input logic [31:0] v, input int lim);
        exp_t e;
        e.cyc = c;
        e.val = v;
        if (c < lim) begin
            if (k == 0) expQ0.push_back(e);
            else        expQ1.push_back(e);
        end
    endtask

    task automatic popCheck(input int k, input string tag, input logic [31:0] v);
        exp_t e;
        bit   have;
        have = (k == 0) ? (expQ0.size() > 0) : (expQ1.size() > 0);
        if (!have) begin
            checkVal($sformatf("%s%0d_unexpected", tag, k), v, 32'hFFFF_FFFF);
        end else begin
            if (k == 0) e = expQ0.pop_front();
            else        e = expQ1.pop_front();
            checkVal($sformatf("%s%0d", tag, k), v, e.val);
            checkVal($sformatf("%s%0d_cycle", tag, k), cyc, e.cyc);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [7:0] rdData = 8'h00;

        // Registered read-mux model: data follows the strobe by one clock
        always @(posedge Mclk) if (rdEn[gi]) rdData <= muxValue;

        lpc_io_slave #(
            .BASE_ADDR  (16'h0800),
            .ADDR_MASK  (16'hFFE0),
            .SYNC_WAITS (gi * 3)
        ) u_dut (
            .Mclk       (Mclk),
            .Reset      (Reset),
            .LFrameN    (LFrameN),
            .LadIn      (LadIn),
            .LadOut     (ladOut[gi]),
            .LadOe      (ladOe[gi]),
            .DevAddr    (devAddr[gi]),
            .RdDev_En   (rdEn[gi]),
            .RdDev_Data (rdData),
            .WrDev_En   (wrEn[gi]),
            .WrDev_Data (wrData[gi])
        );

        // Every observable output event is matched against the scoreboard
        always @(negedge Mclk) begin
            if (!Reset) begin
                if (rdEn[gi]) popCheck(gi, "rd_strobe", {4'h2, 12'h0, devAddr[gi]});
                if (wrEn[gi]) popCheck(gi, "wr_strobe", {4'h3, 4'h0, wrData[gi], devAddr[gi]});
                if (ladOe[gi]) popCheck(gi, "lad", ladEv(ladOut[gi]));
            end
        end
    end

    task automatic drive(input logic f, input logic [3:0] l);
        @(posedge Mclk);
        #1;
        LFrameN = f;
        LadIn   = l;
    endtask

    task automatic checkResetVals(input int k);
        checkVal($sformatf("rst_ladout%0d", k), ladOut[k], 4'hF);
        checkVal($sformatf("rst_ladoe%0d", k), ladOe[k], 1'b0);
        checkVal($sformatf("rst_devaddr%0d", k), devAddr[k], 16'h0000);
        checkVal($sformatf("rst_rden%0d", k), rdEn[k], 1'b0);
        checkVal($sformatf("rst_wren%0d", k), wrEn[k], 1'b0);
        checkVal($sformatf("rst_wrdata%0d", k), wrData[k], 8'h00);
    endtask

    // One host cycle; rstAt >= 0 asserts reset that many clocks after START
    task automatic hostCycle(input string name, input logic [3:0] cycTyp, input logic [15:0] addr,
                             input logic [7:0] data, input int rstAt);
        int s, w, lim;
        bit hit, isRd, isWr;
        drive(1'b0, 4'h0);
        s    = cyc + 1;
        hit  = ((addr & 16'hFFE0) == 16'h0800);
        isRd = (cycTyp[3:1] == 3'b000);
        isWr = (cycTyp[3:1] == 3'b001);
        muxValue = data;
        for (int k = 0; k < 2; k++) begin
            w   = k * 3;
            lim = (rstAt < 0) ? s + 1000 : s + rstAt;
            if (hit && isRd) begin
                pushExp(k, s + 6, {4'h2, 12'h0, addr}, lim);
                for (int i = 0; i < w; i++) pushExp(k, s + 7 + i, ladEv(4'h5), lim);
                pushExp(k, s + 7 + w, ladEv(4'h0), lim);
                pushExp(k, s + 8 + w, ladEv(data[3:0]), lim);
                pushExp(k, s + 9 + w, ladEv(data[7:4]), lim);
                pushExp(k, s + 10 + w, ladEv(4'hF), lim);
            end else if (hit && isWr) begin
                for (int i = 0; i < w; i++) pushExp(k, s + 9 + i, ladEv(4'h5), lim);
                pushExp(k, s + 9 + w, {4'h3, 4'h0, data, addr}, lim);
                pushExp(k, s + 9 + w, ladEv(4'h0), lim);
                pushExp(k, s + 10 + w, ladEv(4'hF), lim);
            end
        end
        drive(1'b1, cycTyp);
        for (int i = 3; i >= 0; i--) drive(1'b1, addr[i*4 +: 4]);
        if (isWr) begin
            drive(1'b1, data[3:0]);
            drive(1'b1, data[7:4]);
        end
        if (rstAt >= 0) begin
            while (cyc < s + rstAt) drive(1'b1, 4'hF);
            checkVal("oe_before_reset", {31'b0, ladOe[0]}, 32'd1);
            #1 Reset = 1'b1;
            #1;
            for (int k = 0; k < 2; k++) checkResetVals(k);
            @(posedge Mclk);
            #1 Reset = 1'b0;
        end else begin
            repeat (14) drive(1'b1, 4'hF);
        end
        $display("txn %s cyctyp %h addr %h data %h start %0d", name, cycTyp, addr, data, s);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge Mclk);
        #1;
        for (int k = 0; k < 2; k++) checkResetVals(k);
        Reset = 1'b0;

        hostCycle("io_read",        4'h0, 16'h0800, 8'hA5, -1);
        hostCycle("io_write",       4'h2, 16'h0809, 8'h3C, -1);
        hostCycle("io_read_miss",   4'h0, 16'h0900, 8'h11, -1);
        hostCycle("io_read",        4'h0, 16'h0801, 8'h5E, -1);
        hostCycle("mem_read",       4'h4, 16'h0800, 8'h22, -1);

        // Abort: START, read CYCTYP, one address nibble, then a fresh START
        drive(1'b0, 4'h0);
        drive(1'b1, 4'h0);
        drive(1'b1, 4'h0);
        $display("txn aborted io_read after one address nibble");
        hostCycle("io_read_after_abort", 4'h0, 16'h0800, 8'hC3, -1);

        hostCycle("io_read_reset",  4'h0, 16'h0800, 8'h96, 8);
        hostCycle("io_read_top",    4'h0, 16'h081F, 8'h7E, -1);
        hostCycle("io_write_miss",  4'h2, 16'h0820, 8'h44, -1);
        hostCycle("io_write",       4'h2, 16'h081E, 8'hE1, -1);

        checkVal("leftover0", expQ0.size(), 32'd0);
        checkVal("leftover1", expQ1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
